// File: rtl/core_mem.sv
// Memory-access stage: EX/MEM register, load/store request/acknowledge FSM,
// MEM/WB register, forwarding outputs and the stall raised while a transaction is open.
module core_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_to_mem,
    input  logic [4:0]  ex_dest_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_memtoreg,
    output logic        dc_req,
    output logic        dc_we,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    input  logic        dc_ack,
    input  logic [31:0] dc_rdata,
    output logic        mem_stall,
    output logic        mem_regwrite,
    output logic [4:0]  mem_regrd,
    output logic [31:0] mem_reg_data,
    output logic        wb_regwrite,
    output logic [4:0]  wb_regrd,
    output logic [31:0] wb_reg_data,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A memory op whose byte address is not word aligned.
    function automatic logic is_misaligned(input logic op, input logic [1:0] byte_off);
        return op & (byte_off != 2'b00);
    endfunction

    logic [31:0] m_alu_r;
    logic [31:0] m_wdata_r;
    logic [4:0]  m_rd_r;
    logic        m_regwrite_r;
    logic        m_memread_r;
    logic        m_memwrite_r;
    logic        m_memtoreg_r;

    state_t      state_r;
    state_t      state_next_s;
    logic        err_set_s;
    logic        err_q_r;
    logic        addr_err_r;
    logic [31:0] rdata_q_r;

    logic        wb_regwrite_r;
    logic [4:0]  wb_regrd_r;
    logic [31:0] wb_reg_data_r;

    logic        memop_s;
    logic        misaligned_s;
    logic        mem_stall_s;
    logic        ack_take_s;

    assign memop_s      = m_memread_r | m_memwrite_r;
    assign misaligned_s = is_misaligned(memop_s, m_alu_r[1:0]);
    // RESP is the one cycle in which a memory op may advance.
    assign mem_stall_s  = memop_s & (state_r != ST_RESP);
    assign ack_take_s   = (state_r == ST_REQ) & dc_ack;

    // EX/MEM pipeline register, frozen while a memory op is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_alu_r      <= 32'd0;
            m_wdata_r    <= 32'd0;
            m_rd_r       <= 5'd0;
            m_regwrite_r <= 1'b0;
            m_memread_r  <= 1'b0;
            m_memwrite_r <= 1'b0;
            m_memtoreg_r <= 1'b0;
        end else if (!mem_stall_s) begin
            m_alu_r      <= alu_result;
            m_wdata_r    <= data_to_mem;
            m_rd_r       <= ex_dest_rd;
            m_regwrite_r <= ex_regwrite;
            m_memread_r  <= ex_memread;
            m_memwrite_r <= ex_memwrite;
            m_memtoreg_r <= ex_memtoreg;
        end
    end

    // Next-state logic of the request/acknowledge FSM.
    always_comb begin
        state_next_s = state_r;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (misaligned_s) begin
                    state_next_s = ST_RESP;
                    err_set_s    = 1'b1;
                end else if (memop_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dc_ack) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, transaction error flag, sticky address error and load-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            err_q_r    <= 1'b0;
            addr_err_r <= 1'b0;
            rdata_q_r  <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            addr_err_r <= addr_err_r | err_set_s;
            if (err_set_s) begin
                err_q_r <= 1'b1;
            end else if (state_r == ST_RESP) begin
                err_q_r <= 1'b0;
            end
            if (ack_take_s) begin
                rdata_q_r <= dc_rdata;
            end
        end
    end

    // MEM/WB pipeline register; a bubble is inserted while the stage is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_regwrite_r <= 1'b0;
            wb_regrd_r    <= 5'd0;
            wb_reg_data_r <= 32'd0;
        end else if (!mem_stall_s) begin
            wb_regwrite_r <= m_regwrite_r & ~err_q_r;
            wb_regrd_r    <= m_rd_r;
            wb_reg_data_r <= m_memtoreg_r ? rdata_q_r : m_alu_r;
        end else begin
            wb_regwrite_r <= 1'b0;
        end
    end

    assign dc_req       = (state_r == ST_REQ);
    assign dc_we        = m_memwrite_r;
    assign dc_addr      = {m_alu_r[31:2], 2'b00};
    assign dc_wdata     = m_wdata_r;
    assign mem_stall    = mem_stall_s;
    // Load data is not available in MEM, so loads never forward from here.
    assign mem_regwrite = m_regwrite_r & ~m_memread_r;
    assign mem_regrd    = m_rd_r;
    assign mem_reg_data = m_alu_r;
    assign wb_regwrite  = wb_regwrite_r;
    assign wb_regrd     = wb_regrd_r;
    assign wb_reg_data  = wb_reg_data_r;
    assign addr_err     = addr_err_r;

endmodule

// File: tb/tb_core_mem.sv
// Bench for core_mem: directed vector table, two multi-cycle sequences and a
// randomized run checked against a per-instruction timing model.
module tb_core_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] data_to_mem = 32'd0;
    logic [4:0]  ex_dest_rd = 5'd0;
    logic        ex_regwrite = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0, ex_memtoreg = 1'b0;
    logic        dc_ack = 1'b0;
    logic [31:0] dc_rdata = 32'd0;
    logic        dc_req, dc_we, mem_stall, mem_regwrite, wb_regwrite, addr_err;
    logic [31:0] dc_addr, dc_wdata, mem_reg_data, wb_reg_data;
    logic [4:0]  mem_regrd, wb_regrd;

    always #5 clk = ~clk;

    core_mem dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .data_to_mem(data_to_mem),
        .ex_dest_rd(ex_dest_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .dc_req(dc_req),
        .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_ack(dc_ack),
        .dc_rdata(dc_rdata), .mem_stall(mem_stall), .mem_regwrite(mem_regwrite),
        .mem_regrd(mem_regrd), .mem_reg_data(mem_reg_data), .wb_regwrite(wb_regwrite),
        .wb_regrd(wb_regrd), .wb_reg_data(wb_reg_data), .addr_err(addr_err)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        regwrite, memread, memwrite, memtoreg;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          waits;
        logic [31:0] rdata;
        logic        exp_mem_we;
        int          exp_stall;
        int          exp_req;
        logic        exp_wb_we;
        logic [31:0] exp_wb_data;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad = 0;
    vec_t vecs[7];
    instr_t nop_i = '0;

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                                  input logic rw, input logic mr, input logic mw, input logic mtr);
        instr_t r;
        r.alu = alu; r.wdata = wd; r.rd = rd;
        r.regwrite = rw; r.memread = mr; r.memwrite = mw; r.memtoreg = mtr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        alu_result = i.alu; data_to_mem = i.wdata; ex_dest_rd = i.rd;
        ex_regwrite = i.regwrite; ex_memread = i.memread;
        ex_memwrite = i.memwrite; ex_memtoreg = i.memtoreg;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; drive(nop_i); dc_ack = 1'b0; dc_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue one instruction into an empty stage and follow it to write-back.
    task automatic run_op(input vec_t v, input int idx);
        int  nstall = 0;
        int  nreq = 0;
        bit  done = 1'b0;
        drive(v.ins);
        dc_ack = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check($sformatf("v%0d_mem_regwrite", idx), 32'(mem_regwrite), 32'(v.exp_mem_we));
                check($sformatf("v%0d_mem_regrd", idx), 32'(mem_regrd), 32'(v.ins.rd));
                check($sformatf("v%0d_mem_reg_data", idx), mem_reg_data, v.ins.alu);
            end
            if (dc_req) begin
                nreq++;
                check($sformatf("v%0d_dc_addr", idx), dc_addr, v.ins.alu & 32'hFFFF_FFFC);
                check($sformatf("v%0d_dc_we", idx), 32'(dc_we), 32'(v.ins.memwrite));
                check($sformatf("v%0d_dc_wdata", idx), dc_wdata, v.ins.wdata);
            end
            if (mem_stall) nstall++;
            else done = 1'b1;
            if (dc_req && nreq == v.waits + 1) begin
                dc_ack = 1'b1; dc_rdata = v.rdata;
            end else begin
                // acknowledge outside a request must be ignored
                dc_ack = ~dc_req; dc_rdata = 32'hBAD0_BAD0;
            end
            if (done) drive(nop_i);
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL v%0d_timeout: stall still high after 40 cycles, expected release", idx);
        end
        @(negedge clk);
        dc_ack = 1'b0;
        check($sformatf("v%0d_stall_cycles", idx), 32'(nstall), 32'(v.exp_stall));
        check($sformatf("v%0d_req_cycles", idx), 32'(nreq), 32'(v.exp_req));
        check($sformatf("v%0d_wb_regwrite", idx), 32'(wb_regwrite), 32'(v.exp_wb_we));
        check($sformatf("v%0d_wb_regrd", idx), 32'(wb_regrd), 32'(v.ins.rd));
        check($sformatf("v%0d_wb_reg_data", idx), wb_reg_data, v.exp_wb_data);
        check($sformatf("v%0d_addr_err", idx), 32'(addr_err), 32'(v.exp_err));
    endtask

    function automatic instr_t gen_instr();
        instr_t i;
        int kind;
        kind = $urandom_range(0, 2);
        i = '0;
        i.alu = $urandom; i.wdata = $urandom; i.rd = 5'($urandom);
        i.regwrite = 1'($urandom);
        if (kind == 1) begin
            i.memread = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1;
        end else if (kind == 2) begin
            i.memwrite = 1'b1;
        end
        if (kind != 0 && $urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
        return i;
    endfunction

    initial begin
        instr_t      cur, nxt;
        int          age, d, occ;
        logic        memop, mis, e_stall, e_req, ack_now, e_wb_we, e_err;
        logic [4:0]  e_wb_rd;
        logic [31:0] e_wb_data, last_rdata, rdata_now;
        logic [6:0]  pattern;

        vecs[0] = '{mk(32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 0, 32'h0,
                    1'b1, 0, 0, 1'b1, 32'h1234_5678, 1'b0};
        vecs[1] = '{mk(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1), 3, 32'hDEAD_BEEF,
                    1'b0, 5, 4, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{mk(32'h0000_0200, 32'hA5A5_A5A5, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0), 0, 32'h0BAD_F00D,
                    1'b0, 2, 1, 1'b0, 32'h0000_0200, 1'b0};
        vecs[3] = '{mk(32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1), 0, 32'h0,
                    1'b0, 1, 0, 1'b0, 32'h0BAD_F00D, 1'b1};
        vecs[4] = '{mk(32'h0000_0203, 32'h7777_7777, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0), 0, 32'h0,
                    1'b1, 1, 0, 1'b0, 32'h0000_0203, 1'b1};
        vecs[5] = '{mk(32'hCAFE_0001, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0), 0, 32'h0,
                    1'b1, 0, 0, 1'b1, 32'hCAFE_0001, 1'b1};
        vecs[6] = '{mk(32'h0000_03FC, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1), 1, 32'h1122_3344,
                    1'b0, 3, 2, 1'b1, 32'h1122_3344, 1'b1};

        // reset state while rst is held low
        #3;
        check("rst_dc_req", 32'(dc_req), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rst_mem_regwrite", 32'(mem_regwrite), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_wb_reg_data", wb_reg_data, 32'd0);
        check("rst_dc_addr", dc_addr, 32'd0);

        do_reset();
        for (int k = 0; k < 7; k++) run_op(vecs[k], k);

        // back-to-back load then store, both acknowledged at once
        do_reset();
        drive(mk(32'h0000_0040, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1));
        pattern = 7'd0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            pattern[c] = dc_req;
            if (c == 3) begin
                check("b2b_load_wb_data", wb_reg_data, 32'h600D_600D);
                check("b2b_load_wb_we", 32'(wb_regwrite), 32'd1);
            end
            if (c == 4 && dc_req) begin
                check("b2b_store_addr", dc_addr, 32'h0000_0080);
                check("b2b_store_we", 32'(dc_we), 32'd1);
                check("b2b_store_wdata", dc_wdata, 32'h55AA_55AA);
            end
            dc_ack = (c == 1 || c == 4);
            dc_rdata = 32'h600D_600D;
            if (c == 2) drive(mk(32'h0000_0080, 32'h55AA_55AA, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            if (c == 5) drive(nop_i);
        end
        dc_ack = 1'b0;
        check("b2b_req_pattern", 32'(pattern), 32'(7'b0010010));

        // reset while a request is outstanding
        do_reset();
        run_op('{mk(32'h0000_0301, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1), 0, 32'h0,
                 1'b0, 1, 0, 1'b0, 32'h0, 1'b1}, 7);
        drive(mk(32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        @(negedge clk);
        check("rstreq_pre_req", 32'(dc_req), 32'd1);
        drive(nop_i);
        #2 rst = 1'b0;
        #1;
        check("rstreq_dc_req", 32'(dc_req), 32'd0);
        check("rstreq_mem_stall", 32'(mem_stall), 32'd0);
        check("rstreq_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rstreq_addr_err", 32'(addr_err), 32'd0);
        dc_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstreq_late_ack_req", 32'(dc_req), 32'd0);
        check("rstreq_late_ack_stall", 32'(mem_stall), 32'd0);
        dc_ack = 1'b0;

        // randomized run against the instruction-level timing model
        do_reset();
        cur = '0; age = 0; d = 0;
        e_wb_we = 1'b0; e_wb_rd = 5'd0; e_wb_data = 32'd0; e_err = 1'b0; last_rdata = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            if (n > 0) @(negedge clk);
            memop   = cur.memread | cur.memwrite;
            mis     = memop && (cur.alu[1:0] != 2'b00);
            occ     = !memop ? 1 : (mis ? 2 : 3 + d);
            e_stall = memop && (age < occ - 1);
            e_req   = memop && !mis && (age >= 1) && (age <= 1 + d);
            check("rnd_mem_stall", 32'(mem_stall), 32'(e_stall));
            check("rnd_dc_req", 32'(dc_req), 32'(e_req));
            check("rnd_wb_regwrite", 32'(wb_regwrite), 32'(e_wb_we));
            check("rnd_wb_regrd", 32'(wb_regrd), 32'(e_wb_rd));
            check("rnd_wb_reg_data", wb_reg_data, e_wb_data);
            check("rnd_addr_err", 32'(addr_err), 32'(e_err));
            check("rnd_mem_regwrite", 32'(mem_regwrite), 32'(cur.regwrite & ~cur.memread));
            check("rnd_mem_reg_data", mem_reg_data, cur.alu);
            if (e_req) begin
                check("rnd_dc_addr", dc_addr, {cur.alu[31:2], 2'b00});
                check("rnd_dc_we", 32'(dc_we), 32'(cur.memwrite));
                check("rnd_dc_wdata", dc_wdata, cur.wdata);
            end
            ack_now   = e_req && (age == 1 + d);
            rdata_now = $urandom;
            dc_ack    = ack_now ? 1'b1 : (!e_req && $urandom_range(0, 3) == 0);
            dc_rdata  = rdata_now;
            if (mis && age == 0) e_err = 1'b1;
            if (!e_stall) begin
                e_wb_we   = cur.regwrite & ~mis;
                e_wb_rd   = cur.rd;
                e_wb_data = cur.memtoreg ? last_rdata : cur.alu;
                nxt = gen_instr();
                drive(nxt);
                cur = nxt; age = 0; d = $urandom_range(0, 3);
            end else begin
                e_wb_we = 1'b0;
                age++;
            end
            if (ack_now) last_rdata = rdata_now;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
